// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
//
// Definitions shared by both ends of the image-over-UART link: the transmit
// framer and the receive deframer (uart_frame_rx).
//
// A frame on the wire is:
//   header  : SEND_MODE, ~SEND_MODE
//   payload : IMAGE_SIZE pixels, each sent low byte first, then high byte
//   trailer : ~SEND_MODE, SEND_MODE
//
// Contents:
//   frame_state_t        - deframer state encoding (also used for debug)
//   IMAGE_SIZE_DEF       - default pixels per frame (320*240)
//   SEND_MODE_DEF        - default mode byte
//   TIMEOUT_CYC_DEF      - default inter-byte timeout in clock cycles
//   hdr_byte / trl_byte  - byte order of the header and trailer for a mode
// ---------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,  // idle, searching for the first header byte
    HDR1   = 3'd1,  // first header byte seen, expecting its complement
    PIX_LO = 3'd2,  // expecting the low byte of a pixel
    PIX_HI = 3'd3,  // expecting the high byte of a pixel
    TRL0   = 3'd4,  // payload complete, expecting first trailer byte
    TRL1   = 3'd5   // expecting second trailer byte
  } frame_state_t;

  localparam int          IMAGE_SIZE_DEF  = 76800;
  localparam logic [7:0]  SEND_MODE_DEF   = 8'h01;
  localparam int          TIMEOUT_CYC_DEF = 100000;

  // Header is (mode, ~mode). idx selects the byte position in the header.
  function automatic logic [7:0] hdr_byte(input logic [7:0] mode, input logic idx);
    return idx ? ~mode : mode;
  endfunction

  // Trailer is the header reversed: (~mode, mode).
  function automatic logic [7:0] trl_byte(input logic [7:0] mode, input logic idx);
    return idx ? mode : ~mode;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// ---------------------------------------------------------------------------
// uart_byte_timeout
//
// Inter-byte watchdog. Counts clock cycles since the last received byte while
// enabled and flags expiry once TIMEOUT_CYC-1 idle cycles have accumulated.
//
// Ports:
//   SYS_CLK  in   clock
//   RST      in   asynchronous active-high reset
//   clear    in   a byte arrived this cycle; restart the count
//   enable   in   count only while a frame is in progress
//   expire   out  combinational; count is at its limit and no byte arrived
//                 this cycle (a byte arriving in the expiry cycle wins)
// ---------------------------------------------------------------------------
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = uart_frame_pkg::TIMEOUT_CYC_DEF
) (
  input  logic SYS_CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int              CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // The count saturates at LAST so it can never wrap if the owner is slow
  // to leave its busy state; disabling the counter also returns it to zero.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//
// Receive-side deframer for the image-over-UART link. Consumes bytes from
// the UART byte receiver, finds the header, reassembles 16-bit pixels from
// low/high byte pairs into the frame-buffer write FIFO, then checks the
// trailer and reports completion or error.
//
// Interface semantics:
//   rx_valid/rx_data : one-cycle strobe, no backpressure toward the UART.
//                      Only cycles with rx_valid=1 advance the deframer.
//   wr_req/wr_data   : one-cycle FIFO write strobe with its pixel, issued the
//                      cycle after the high-byte strobe. The FIFO cannot stall
//                      the link, so a pixel arriving while wr_full=1 is
//                      dropped (counted, flagged in overflow, never written).
//
// Ports:
//   SYS_CLK     in   clock
//   RST         in   asynchronous active-high reset
//   rx_data     in   received byte
//   rx_valid    in   byte strobe
//   wr_data     out  assembled pixel {high, low}
//   wr_req      out  FIFO write strobe
//   wr_full     in   FIFO full
//   frame_done  out  pulse: frame received with a correct trailer
//   frame_err   out  pulse: bad trailer or inter-byte timeout
//   overflow    out  sticky: a pixel was dropped; cleared on next header
//   pix_cnt     out  pixels received in the current frame (saturating)
//   busy        out  high whenever a frame is in progress (state != HUNT)
//   state_dbg   out  current deframer state
// ---------------------------------------------------------------------------
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         IMAGE_SIZE  = IMAGE_SIZE_DEF,
  parameter logic [7:0] SEND_MODE   = SEND_MODE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int        CNT_W       = $clog2(IMAGE_SIZE + 1)
) (
  input  logic             SYS_CLK,
  input  logic             RST,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [15:0]      wr_data,
  output logic             wr_req,
  input  logic             wr_full,
  output logic             frame_done,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             busy,
  output frame_state_t     state_dbg
);

  localparam logic [7:0]       HDR0    = hdr_byte(SEND_MODE, 1'b0);
  localparam logic [7:0]       HDR1_B  = hdr_byte(SEND_MODE, 1'b1);
  localparam logic [7:0]       TRL0_B  = trl_byte(SEND_MODE, 1'b0);
  localparam logic [7:0]       TRL1_B  = trl_byte(SEND_MODE, 1'b1);
  localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(IMAGE_SIZE);

  frame_state_t     state;
  logic [7:0]       low_byte;
  logic [CNT_W-1:0] pix_cnt_inc;
  logic             to_expire;

  // Saturating increment: pix_cnt never moves past IMAGE_SIZE.
  always_comb begin
    pix_cnt_inc = pix_cnt;
    if (pix_cnt != PIX_MAX) begin
      pix_cnt_inc = pix_cnt + 1'b1;
    end
  end

  uart_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .clear   (rx_valid),
    .enable  (state != HUNT),
    .expire  (to_expire)
  );

  // Deframer. Pulsed outputs default low every cycle. Payload bytes are never
  // compared against framing values, so 0x01/0xFE pixels pass through as data
  // and a header appearing inside the payload is just two more data bytes.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state      <= HUNT;
      wr_req     <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      pix_cnt    <= '0;
      low_byte   <= '0;
    end else begin
      wr_req     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (rx_valid) begin
        case (state)
          HUNT: begin
            if (rx_data == HDR0) begin
              state <= HDR1;
            end
          end

          HDR1: begin
            if (rx_data == HDR1_B) begin
              state    <= PIX_LO;
              pix_cnt  <= '0;
              overflow <= 1'b0;
            end else if (rx_data == HDR0) begin
              // Repeated first header byte: treat it as the new start.
              state <= HDR1;
            end else begin
              state <= HUNT;
            end
          end

          PIX_LO: begin
            low_byte <= rx_data;
            state    <= PIX_HI;
          end

          PIX_HI: begin
            wr_data <= {rx_data, low_byte};
            wr_req  <= ~wr_full;
            if (wr_full) begin
              overflow <= 1'b1;
            end
            // Dropped pixels still count, so the trailer stays aligned.
            pix_cnt <= pix_cnt_inc;
            state   <= (pix_cnt_inc == PIX_MAX) ? TRL0 : PIX_LO;
          end

          TRL0: begin
            if (rx_data == TRL0_B) begin
              state <= TRL1;
            end else begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end
          end

          TRL1: begin
            if (rx_data == TRL1_B) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= HUNT;
          end

          default: begin
            state <= HUNT;
          end
        endcase
      end else if (to_expire) begin
        // pix_cnt is left alone so the truncation point stays visible.
        frame_err <= 1'b1;
        state     <= HUNT;
      end
    end
  end

  assign busy      = (state != HUNT);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_rx
//
// Builds frames byte by byte (clean, bad trailer, truncated), and for each
// frame records what must come out: the pixels that reach the FIFO and the
// end-of-frame event with the overflow flag and pixel count at that moment.
// A monitor compares every wr_req and every frame_done/frame_err pulse
// against those expectations.
// ---------------------------------------------------------------------------
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int         IMG  = 4;
  localparam int         TO   = 50;
  localparam logic [7:0] MODE = 8'h01;
  localparam int         CW   = $clog2(IMG + 1);

  logic          SYS_CLK;
  logic          RST;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [15:0]   wr_data;
  logic          wr_req;
  logic          wr_full;
  logic          frame_done;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] pix_cnt;
  logic          busy;
  frame_state_t  state_dbg;

  uart_frame_rx #(
    .IMAGE_SIZE  (IMG),
    .SEND_MODE   (MODE),
    .TIMEOUT_CYC (TO)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .RST        (RST),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_data    (wr_data),
    .wr_req     (wr_req),
    .wr_full    (wr_full),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .pix_cnt    (pix_cnt),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    SYS_CLK = 1'b0;
    forever #5 SYS_CLK = ~SYS_CLK;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  // end-of-frame events: {is_err, overflow, pix_cnt}
  logic [CW+1:0] ev_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW+1:0] mk_ev(input logic is_err, input logic ovf, input int cnt);
    return {is_err, ovf, CW'(cnt)};
  endfunction

  always @(negedge SYS_CLK) begin
    if (!RST) begin
      if (wr_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_req", 32'(wr_data), 32'hFFFF_FFFF);
        end else begin
          check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done && frame_err) begin
        check("done_and_err", 32'(1), 32'(0));
      end else if (frame_done || frame_err) begin
        if (ev_q.size() == 0) begin
          check("unexpected_frame_event", 32'({frame_err, overflow, pix_cnt}), 32'hFFFF_FFFF);
        end else begin
          check("frame_event", 32'({frame_err, overflow, pix_cnt}), 32'(ev_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called aligned to a falling edge; leaves the bench aligned to one.
  task automatic send_byte(input logic [7:0] b, input logic full);
    rx_data  = b;
    rx_valid = 1'b1;
    wr_full  = full;
    @(negedge SYS_CLK);
    rx_valid = 1'b0;
    wr_full  = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge SYS_CLK);
  endtask

  task automatic send_pixel(input logic [15:0] px, input logic full);
    send_byte(px[7:0], 1'b0);
    if (!full) exp_q.push_back(px);
    send_byte(px[15:8], full);
  endtask

  function automatic logic [7:0] rand_byte_not(input logic [7:0] avoid);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == avoid) b = b ^ 8'h5A;
    return b;
  endfunction

  // kind 0: clean, 1: bad trailer, 2: truncated then silence
  task automatic random_frame(input int kind);
    logic ovf;
    logic full;
    int   npix;
    ovf  = 1'b0;
    npix = (kind == 2) ? int'($urandom_range(0, IMG - 1)) : IMG;
    if ($urandom_range(0, 3) == 0) send_byte(rand_byte_not(MODE), 1'b0);
    send_byte(MODE, 1'b0);
    if ($urandom_range(0, 3) == 0) send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    for (int p = 0; p < npix; p++) begin
      full = ($urandom_range(0, 5) == 0);
      if (full) ovf = 1'b1;
      send_pixel(16'($urandom_range(0, 65535)), full);
    end
    case (kind)
      0: begin
        send_byte(~MODE, 1'b0);
        ev_q.push_back(mk_ev(1'b0, ovf, IMG));
        send_byte(MODE, 1'b0);
      end
      1: begin
        if ($urandom_range(0, 1) == 0) begin
          send_byte(~MODE, 1'b0);
          ev_q.push_back(mk_ev(1'b1, ovf, IMG));
          send_byte(rand_byte_not(MODE), 1'b0);
        end else begin
          ev_q.push_back(mk_ev(1'b1, ovf, IMG));
          send_byte(rand_byte_not(~MODE), 1'b0);
          send_byte(rand_byte_not(MODE), 1'b0);
        end
      end
      default: begin
        if ($urandom_range(0, 1) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0);
        ev_q.push_back(mk_ev(1'b1, ovf, npix));
        repeat (TO + 5) @(negedge SYS_CLK);
      end
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    wr_full  = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    check("reset_outputs", 32'({wr_req, frame_done, frame_err, overflow, busy, pix_cnt, wr_data}), 32'(0));
    check("reset_state", 32'(state_dbg), 32'(HUNT));
    RST = 1'b0;
    @(negedge SYS_CLK);

    // Clean frame with the reference bytes.
    send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    send_pixel(16'h1234, 1'b0);
    send_pixel(16'h5678, 1'b0);
    send_pixel(16'h9ABC, 1'b0);
    send_pixel(16'hDEF0, 1'b0);
    send_byte(8'hFE, 1'b0);
    ev_q.push_back(mk_ev(1'b0, 1'b0, IMG));
    send_byte(8'h01, 1'b0);
    @(negedge SYS_CLK);
    check("clean_pix_cnt", 32'(pix_cnt), 32'(IMG));
    check("clean_busy", 32'(busy), 32'(0));

    // Bad trailer FE 02.
    send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    for (int p = 0; p < IMG; p++) send_pixel(16'(p * 16'h0101 + 16'h01FE), 1'b0);
    send_byte(8'hFE, 1'b0);
    ev_q.push_back(mk_ev(1'b1, 1'b0, IMG));
    send_byte(8'h02, 1'b0);
    @(negedge SYS_CLK);
    check("badtrl_state", 32'(state_dbg), 32'(HUNT));

    // Backpressure on the second pixel, then the next header clears overflow.
    send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    send_pixel(16'hA1A0, 1'b0);
    send_pixel(16'hB1B0, 1'b1);
    send_pixel(16'hC1C0, 1'b0);
    send_pixel(16'hD1D0, 1'b0);
    send_byte(8'hFE, 1'b0);
    ev_q.push_back(mk_ev(1'b0, 1'b1, IMG));
    send_byte(8'h01, 1'b0);
    @(negedge SYS_CLK);
    check("bp_overflow_sticky", 32'(overflow), 32'(1));
    send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    check("hdr_clears_overflow", 32'(overflow), 32'(0));
    check("hdr_clears_pix_cnt", 32'(pix_cnt), 32'(0));
    for (int p = 0; p < IMG; p++) send_pixel(16'($urandom_range(0, 65535)), 1'b0);
    send_byte(8'hFE, 1'b0);
    ev_q.push_back(mk_ev(1'b0, 1'b0, IMG));
    send_byte(8'h01, 1'b0);

    // Timeout after one low byte.
    send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    ev_q.push_back(mk_ev(1'b1, 1'b0, 0));
    send_byte(8'h34, 1'b0);
    repeat (TO + 5) @(negedge SYS_CLK);
    check("timeout_busy", 32'(busy), 32'(0));
    check("timeout_state", 32'(state_dbg), 32'(HUNT));

    // Reset in the middle of the second pixel.
    send_byte(MODE, 1'b0);
    send_byte(~MODE, 1'b0);
    send_pixel(16'h1234, 1'b0);
    send_byte(8'h78, 1'b0);
    @(negedge SYS_CLK);
    #2 RST = 1'b1;
    #1;
    check("async_reset_outputs", 32'({wr_req, frame_done, frame_err, overflow, busy, pix_cnt, wr_data}), 32'(0));
    check("async_reset_state", 32'(state_dbg), 32'(HUNT));
    @(negedge SYS_CLK);
    RST = 1'b0;
    @(negedge SYS_CLK);
    send_byte(8'h12, 1'b0);
    repeat (3) @(negedge SYS_CLK);
    check("post_reset_pix_cnt", 32'(pix_cnt), 32'(0));

    // Randomized mix.
    for (int f = 0; f < 40; f++) begin
      random_frame(int'($urandom_range(0, 2)));
    end

    // Drain, bounded.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || ev_q.size() != 0); i++) begin
      @(negedge SYS_CLK);
    end
    check("pixels_outstanding", 32'(exp_q.size()), 32'(0));
    check("events_outstanding", 32'(ev_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
